// File: rtl/snoop_bus_arbiter_if.sv
// snoop_bus_arbiter_if: request, snoop, memory and bus signals shared between
// the snooping-bus arbiter (master) and the cache controllers/memory (slave).
interface snoop_bus_arbiter_if #(
    parameter int NREQ  = 3,
    parameter int BUS_W = 10
);
    logic [NREQ-1:0]       req;
    logic [NREQ*BUS_W-1:0] req_msg;
    logic [NREQ-1:0]       snoop_shared;
    logic [NREQ-1:0]       snoop_wb;
    logic [NREQ*BUS_W-1:0] snoop_wb_msg;
    logic [BUS_W-1:0]      mem_rdata;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       snoop_en;
    logic [BUS_W-1:0]      bus;
    logic                  bus_valid;
    logic                  shared;
    logic                  mem_we;
    logic                  mem_re;
    logic                  done;

    modport master (
        input  req, req_msg, snoop_shared, snoop_wb, snoop_wb_msg, mem_rdata,
        output grant, snoop_en, bus, bus_valid, shared, mem_we, mem_re, done
    );

    modport slave (
        output req, req_msg, snoop_shared, snoop_wb, snoop_wb_msg, mem_rdata,
        input  grant, snoop_en, bus, bus_valid, shared, mem_we, mem_re, done
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin owner of the shared snooping bus, sequencing
// address broadcast, snoop window, optional write-back, memory read and data return.
module snoop_bus_arbiter #(
    parameter int NREQ      = 3,
    parameter int BUS_W     = 10,
    parameter int SNOOP_CYC = 2
) (
    input logic                 clock,
    input logic                 clear,
    snoop_bus_arbiter_if.master sb
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(SNOOP_CYC + 1);

    typedef enum logic [2:0] {IDLE, ADDR, SNOOP, WB, MEM, DATA} state_t;

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    win;
    logic [IW-1:0]    wb_sel;
    logic [IW:0]      idx;
    logic [CW-1:0]    cnt;
    logic [BUS_W-1:0] msg;
    logic [BUS_W-1:0] wb_msg;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  wb_hit;
    logic             shared;

    // Scan backwards so the last hit written is the first requester after rr_ptr.
    always_comb begin
        win = rr_ptr;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
            if (sb.req[idx[IW-1:0]]) win = idx[IW-1:0];
        end
    end

    always_comb begin
        wb_hit = sb.snoop_wb & ~grant;
        wb_sel = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (wb_hit[i]) wb_sel = IW'(i);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            cnt    <= '0;
            msg    <= '0;
            wb_msg <= '0;
            grant  <= '0;
            shared <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|sb.req) begin
                    owner <= win;
                    grant <= NREQ'(1) << win;
                    msg   <= sb.req_msg[int'(win)*BUS_W +: BUS_W];
                    state <= ADDR;
                end
                ADDR: begin
                    cnt   <= '0;
                    state <= SNOOP;
                end
                SNOOP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SNOOP_CYC - 1)) begin
                        shared <= |(sb.snoop_shared & ~grant);
                        if (|wb_hit) begin
                            wb_msg <= sb.snoop_wb_msg[int'(wb_sel)*BUS_W +: BUS_W];
                            state  <= WB;
                        end else begin
                            state <= MEM;
                        end
                    end
                end
                WB:   state <= MEM;
                MEM:  state <= DATA;
                DATA: begin
                    rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    grant  <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sb.grant     = grant;
    assign sb.snoop_en  = (state == ADDR || state == SNOOP) ? ~grant : '0;
    assign sb.bus       = (state == ADDR) ? msg :
                          (state == WB)   ? wb_msg :
                          (state == DATA) ? sb.mem_rdata : '0;
    assign sb.bus_valid = (state == ADDR) || (state == WB) || (state == DATA);
    assign sb.shared    = shared;
    assign sb.mem_we    = (state == WB);
    assign sb.mem_re    = (state == MEM);
    assign sb.done      = (state == DATA);
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed cycle-by-cycle checks of arbitration order,
// phase sequencing, snoop sampling, write-back selection and async clear.
module tb_snoop_bus_arbiter;
    localparam logic [9:0] M0 = 10'b00_01_000_000;
    localparam logic [9:0] M1 = 10'h0C9;
    localparam logic [9:0] M2 = 10'h1B2;
    localparam logic [9:0] W0 = 10'h155;
    localparam logic [9:0] W1 = 10'b00_01_000_011;
    localparam logic [9:0] W2 = 10'h3C7;
    localparam logic [9:0] Z  = 10'h000;

    logic clock;
    logic clear;
    int   n_chk;
    int   n_fail;

    snoop_bus_arbiter_if #(.NREQ(3), .BUS_W(10)) sb ();

    snoop_bus_arbiter #(.NREQ(3), .BUS_W(10), .SNOOP_CYC(2)) dut (
        .clock (clock),
        .clear (clear),
        .sb    (sb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic eo(input string tag, input logic [2:0] g, input logic [2:0] se,
                      input logic [9:0] b, input logic v, input logic s,
                      input logic we, input logic re, input logic dn);
        logic [20:0] obs;
        logic [20:0] exp;
        obs = {sb.grant, sb.snoop_en, sb.bus, sb.bus_valid, sb.shared, sb.mem_we, sb.mem_re, sb.done};
        exp = {g, se, b, v, s, we, re, dn};
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed grant=%b en=%b bus=%h valid=%b shared=%b we=%b re=%b done=%b, expected grant=%b en=%b bus=%h valid=%b shared=%b we=%b re=%b done=%b",
                   tag, sb.grant, sb.snoop_en, sb.bus, sb.bus_valid, sb.shared, sb.mem_we, sb.mem_re, sb.done,
                   g, se, b, v, s, we, re, dn);
        end
    endtask

    logic [2:0] g2 [4];
    logic [9:0] m2 [4];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        g2 = '{3'b001, 3'b010, 3'b100, 3'b001};
        m2 = '{M0, M1, M2, M0};
        clear           = 1'b0;
        sb.req          = 3'b000;
        sb.req_msg      = {M2, M1, M0};
        sb.snoop_shared = 3'b000;
        sb.snoop_wb     = 3'b000;
        sb.snoop_wb_msg = {W2, W1, W0};
        sb.mem_rdata    = Z;
        #3 eo("reset", 3'b000, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.req = 3'b111;
        tick();
        eo("reset_hold", 3'b000, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.req = 3'b000;
        #2 clear = 1'b1;
        tick();
        eo("idle", 3'b000, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // single requester, no snoop hits
        sb.req = 3'b001;
        tick();
        eo("t1_addr", 3'b001, 3'b110, M0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        eo("t1_snoop1", 3'b001, 3'b110, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        eo("t1_snoop2", 3'b001, 3'b110, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.mem_rdata = 10'h2A5;
        tick();
        eo("t1_mem", 3'b001, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        eo("t1_data", 3'b001, 3'b000, 10'h2A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sb.mem_rdata = 10'h15A;
        #1 eo("t1_passthru", 3'b001, 3'b000, 10'h15A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sb.req = 3'b000;
        tick();
        eo("t1_idle", 3'b000, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // restart from rr_ptr=0 for the fairness sequence
        clear = 1'b0;
        #2 clear = 1'b1;
        sb.mem_rdata = 10'h011;
        sb.req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            tick();
            eo($sformatf("t2_addr%0d", t), g2[t], ~g2[t], m2[t], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            tick();
            tick();
            eo($sformatf("t2_mem%0d", t), g2[t], 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            eo($sformatf("t2_data%0d", t), g2[t], 3'b000, 10'h011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            eo($sformatf("t2_gap%0d", t), 3'b000, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        sb.req = 3'b000;
        // CPU1 owner, non-owner sharers
        tick();
        sb.req = 3'b010;
        sb.snoop_shared = 3'b101;
        tick();
        eo("t3_addr", 3'b010, 3'b101, M1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        eo("t3_mem", 3'b010, 3'b000, Z, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        eo("t3_data", 3'b010, 3'b000, 10'h011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        sb.req = 3'b000;
        tick();
        eo("t3_idle_hold", 3'b000, 3'b000, Z, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // CPU1 owner, only the owner claims shared
        sb.req = 3'b010;
        sb.snoop_shared = 3'b010;
        tick();
        eo("t3b_addr", 3'b010, 3'b101, M1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        eo("t3b_mem", 3'b010, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        sb.req = 3'b000;
        sb.snoop_shared = 3'b000;
        tick();
        // CPU0 owner, two dirty snoopers: lowest index wins
        sb.req = 3'b001;
        sb.snoop_wb = 3'b110;
        tick();
        eo("t4_addr", 3'b001, 3'b110, M0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        eo("t4_snoop2", 3'b001, 3'b110, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        eo("t4_wb", 3'b001, 3'b000, W1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sb.snoop_wb = 3'b000;
        tick();
        eo("t4_mem", 3'b001, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        eo("t4_data", 3'b001, 3'b000, 10'h011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sb.req = 3'b000;
        tick();
        // owner's own write-back flag must not create a WB phase
        sb.req = 3'b001;
        sb.snoop_wb = 3'b001;
        tick();
        eo("t4b_addr", 3'b001, 3'b110, M0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        eo("t4b_mem", 3'b001, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        eo("t4b_data", 3'b001, 3'b000, 10'h011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sb.req = 3'b000;
        sb.snoop_wb = 3'b000;
        tick();
        // async clear in the middle of the snoop window
        sb.req = 3'b100;
        tick();
        eo("t5_addr", 3'b100, 3'b011, M2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        eo("t5_snoop1", 3'b100, 3'b011, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 clear = 1'b0;
        #1 eo("t5_clear", 3'b000, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 clear = 1'b1;
        sb.req = 3'b010;
        tick();
        eo("t5_regrant", 3'b010, 3'b101, M1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // owner drops req mid-transaction
        tick();
        sb.req = 3'b000;
        tick();
        tick();
        eo("t6_mem", 3'b010, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        eo("t6_data", 3'b010, 3'b000, 10'h011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        eo("t6_idle", 3'b000, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // rr_ptr now 2: CPU2 beats CPU1
        sb.req = 3'b110;
        tick();
        eo("t6_rr_addr", 3'b100, 3'b011, M2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        sb.req = 3'b011;
        tick();
        eo("t6_nonowner_req", 3'b100, 3'b011, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        eo("t6_rr_data", 3'b100, 3'b000, 10'h011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sb.req = 3'b000;
        tick();
        eo("final_idle", 3'b000, 3'b000, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
